gray_code_source: RTL

Generates the 4-bit Gray code consumed by the Gray decoding and display path. It maintains a modulo-16 binary counter driven by two debounced push buttons (up/down) and a direct synchronous load. It outputs the Gray encoding of the count, plus the plain binary value for cross-checking. It sits between the board buttons/switches and the `gray_code` input of the top-level decoder, closing the loop so the display path can be exercised on hardware without external Gray stimulus.

---
 rtl/gray_code_source.sv | 125 ++++++++++++
 1 files changed

// File: rtl/gray_code_source.sv
// gray_code_source: modulo-16 up/down counter driven by two debounced push
// buttons plus a direct synchronous load, presented as both a registered
// Gray code and the matching registered binary count.
module gray_code_source #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] gray_code,
    output logic [3:0] binary_code,
    output logic       step
);

    // Stability counter must be able to hold DEBOUNCE_CYCLES-1.
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the up button, index 1 the down button.
    logic          btn_raw   [2];
    logic          sync1_q   [2];
    logic          sync1_d   [2];
    logic          sync2_q   [2];
    logic          sync2_d   [2];
    logic          acc_q     [2];
    logic          acc_d     [2];
    logic          acc_dly_q [2];
    logic          acc_dly_d [2];
    logic [CW-1:0] cnt_q     [2];
    logic [CW-1:0] cnt_d     [2];
    logic          press     [2];

    assign btn_raw[0] = btn_up;
    assign btn_raw[1] = btn_down;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            // Synchronizer, debouncer and edge detector next-state logic.
            always_comb begin
                sync1_d[gi]   = btn_raw[gi];
                sync2_d[gi]   = sync1_q[gi];
                acc_d[gi]     = acc_q[gi];
                cnt_d[gi]     = '0;
                acc_dly_d[gi] = acc_q[gi];
                // Count only while the synchronized level disagrees with the
                // accepted one; any return to the accepted level restarts.
                if (sync2_q[gi] != acc_q[gi]) begin
                    if (cnt_q[gi] == CNT_LAST) begin
                        acc_d[gi] = sync2_q[gi];
                        cnt_d[gi] = '0;
                    end else begin
                        cnt_d[gi] = cnt_q[gi] + 1'b1;
                    end
                end
            end

            // Per-button state registers, all cleared by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q[gi]   <= 1'b0;
                    sync2_q[gi]   <= 1'b0;
                    acc_q[gi]     <= 1'b0;
                    acc_dly_q[gi] <= 1'b0;
                    cnt_q[gi]     <= '0;
                end else begin
                    sync1_q[gi]   <= sync1_d[gi];
                    sync2_q[gi]   <= sync2_d[gi];
                    acc_q[gi]     <= acc_d[gi];
                    acc_dly_q[gi] <= acc_dly_d[gi];
                    cnt_q[gi]     <= cnt_d[gi];
                end
            end

            // Rising edge of the accepted level only; releases are ignored.
            assign press[gi] = acc_q[gi] & ~acc_dly_q[gi];
        end
    endgenerate

    logic [3:0] bin_q;
    logic [3:0] bin_d;
    logic [3:0] gray_q;
    logic [3:0] gray_d;
    logic       step_q;
    logic       step_d;

    // Count update: load beats presses, simultaneous presses cancel.
    always_comb begin
        bin_d  = bin_q;
        step_d = 1'b0;
        if (load) begin
            bin_d  = load_value;
            step_d = 1'b1;
        end else if (press[0] && !press[1]) begin
            bin_d  = bin_q + 4'd1;
            step_d = 1'b1;
        end else if (press[1] && !press[0]) begin
            bin_d  = bin_q - 4'd1;
            step_d = 1'b1;
        end
        // Gray is taken from the next binary value so both always agree.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= 4'd0;
            gray_q <= 4'd0;
            step_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            step_q <= step_d;
        end
    end

    assign binary_code = bin_q;
    assign gray_code   = gray_q;
    assign step        = step_q;

endmodule
